// File: rtl/pc_seq_pkg.sv
// Shared types, constants and helpers for the PC fetch sequencer and its
// next-PC datapath.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD
  } seqState_t;

  localparam logic [31:0] PC_INCR         = 32'd4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // Jump target keeps the 256 MB region of the sequential PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection: taken branch over jump over sequential.
module next_pc_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;

  always_comb begin
    pc4     = instr_pc + PC_INCR;
    next_pc = pc4;
    if (branch && alu_zero) begin
      next_pc = pc4 + {branch_offset[29:0], 2'b00};
    end else if (jump) begin
      next_pc = jump_target(pc4, jump_index);
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Handshaked fetch controller: owns the PC, requests instruction memory and
// holds each fetched word until the downstream stage accepts it.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned RESET_SETTLE = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      start_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  input  logic             instr_accept,
  input  logic             branch,
  input  logic             alu_zero,
  input  logic [31:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [3:0] BOOT_INIT = 4'(RESET_SETTLE - 1);

  seqState_t   state;
  logic [3:0]  bootCnt;
  logic [31:0] pc;
  logic [31:0] nextPc;

  next_pc_calc u_nextPc (
    .instr_pc      (instr_pc),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .next_pc       (nextPc)
  );

  // pc only changes while no request is outstanding, so the address is stable.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      bootCnt     <= BOOT_INIT;
      pc          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          if (bootCnt == 4'd0) begin
            pc       <= start_pc & ADDR_ALIGN_MASK;
            imem_req <= 1'b1;
            state    <= S_REQ;
          end else begin
            bootCnt <= bootCnt - 4'd1;
          end
        end
        S_REQ: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_accept) begin
            fetch_count <= fetch_count + CNT_W'(1);
            instr_valid <= 1'b0;
            pc          <= nextPc;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end
        end
        default: begin
          state    <= S_BOOT;
          bootCnt  <= BOOT_INIT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] start_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_accept;
  logic        branch;
  logic        alu_zero;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] fetch_count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] expCount;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.RESET_SETTLE(1), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_pc      (start_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_accept  (instr_accept),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .fetch_count   (fetch_count)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled and inputs changed 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    checkVal({tag, "_addr"}, imem_addr, 32'd0);
    checkVal({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    checkVal({tag, "_instr"}, instr, 32'd0);
    checkVal({tag, "_ipc"}, instr_pc, 32'd0);
    checkVal({tag, "_cnt"}, fetch_count, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_pc = 32'h0040_0003;
    imem_ready = 1'b0; imem_rdata = '0; instr_accept = 1'b0;
    branch = 1'b0; alu_zero = 1'b0; branch_offset = '0; jump = 1'b0; jump_index = '0;
    expCount = '0;

    // Boot
    tick(); checkIdle("rst1");
    tick(); checkIdle("rst2");
    rst = 1'b0;
    tick();
    checkVal("boot_req", {31'd0, imem_req}, 32'd1);
    checkVal("boot_addr", imem_addr, 32'h0040_0000);

    // Sequential stream, zero-wait memory, accept held high
    imem_ready = 1'b1; instr_accept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'hA000_0000 + 32'(i);
      tick();
      checkVal("seq_hold_req", {31'd0, imem_req}, 32'd0);
      checkVal("seq_valid", {31'd0, instr_valid}, 32'd1);
      checkVal("seq_instr", instr, 32'hA000_0000 + 32'(i));
      checkVal("seq_ipc", instr_pc, 32'h0040_0000 + 32'(4 * i));
      tick();
      expCount++;
      checkVal("seq_req", {31'd0, imem_req}, 32'd1);
      checkVal("seq_addr", imem_addr, 32'h0040_0004 + 32'(4 * i));
      checkVal("seq_cnt", fetch_count, expCount);
      checkVal("seq_valid_lo", {31'd0, instr_valid}, 32'd0);
    end

    // Memory stall; accept outside S_HOLD must be ignored
    imem_ready = 1'b0; instr_accept = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkVal("mstall_req", {31'd0, imem_req}, 32'd1);
      checkVal("mstall_addr", imem_addr, 32'h0040_000C);
      checkVal("mstall_cnt", fetch_count, expCount);
    end
    instr_accept = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    // Downstream stall; ready in S_HOLD must not overwrite instr
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal("dstall_valid", {31'd0, instr_valid}, 32'd1);
      checkVal("dstall_instr", instr, 32'h1234_5678);
      checkVal("dstall_ipc", instr_pc, 32'h0040_000C);
      checkVal("dstall_cnt", fetch_count, expCount);
      checkVal("dstall_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ready = 1'b0; instr_accept = 1'b1;
    tick(); expCount++;
    checkVal("dstall_next", imem_addr, 32'h0040_0010);
    checkVal("dstall_cnt2", fetch_count, expCount);

    // Branch taken beats jump; redirect inputs asserted early must be ignored
    instr_accept = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1000_FFFE;
    branch = 1'b1; alu_zero = 1'b1; branch_offset = 32'hFFFF_FFFE;
    jump = 1'b1; jump_index = 26'h010_0000;
    tick();
    checkVal("br_ipc", instr_pc, 32'h0040_0010);
    imem_ready = 1'b0; instr_accept = 1'b1;
    tick(); expCount++;
    checkVal("br_taken_addr", imem_addr, 32'h0040_000C);

    // Back to 0x00400010 sequentially, then untaken branch falls to jump
    branch = 1'b0; jump = 1'b0; instr_accept = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; instr_accept = 1'b1;
    tick(); expCount++;
    checkVal("br_seq_addr", imem_addr, 32'h0040_0010);
    instr_accept = 1'b0; imem_ready = 1'b1;
    tick();
    branch = 1'b1; alu_zero = 1'b0; jump = 1'b1;
    imem_ready = 1'b0; instr_accept = 1'b1;
    tick(); expCount++;
    checkVal("br_untaken_jump", imem_addr, 32'h0040_0000);
    checkVal("br_cnt", fetch_count, expCount);
    branch = 1'b0; alu_zero = 1'b0; jump = 1'b0; instr_accept = 1'b0;

    // Reset mid-fetch (S_REQ, ready low), then reboot at the wrap boundary
    tick();
    rst = 1'b1; start_pc = 32'h1111_1111;
    tick();
    checkVal("mid_rst_req", {31'd0, imem_req}, 32'd0);
    checkVal("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    checkVal("mid_rst_cnt", fetch_count, 32'd0);
    rst = 1'b0; start_pc = 32'hFFFF_FFFF;
    tick();
    checkVal("reboot_addr", imem_addr, 32'hFFFF_FFFC);
    checkVal("reboot_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1; imem_rdata = 32'h0BAD_F00D;
    tick();
    checkVal("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    imem_ready = 1'b0; instr_accept = 1'b1;
    tick();
    checkVal("wrap_addr", imem_addr, 32'h0000_0000);
    checkVal("wrap_cnt", fetch_count, 32'd1);

    // Negative branch offset wrapping below zero: 0x0 + 4 + (-3 << 2) = 0xFFFFFFF8
    instr_accept = 1'b0; imem_ready = 1'b1;
    tick();
    branch = 1'b1; alu_zero = 1'b1; branch_offset = 32'hFFFF_FFFD;
    imem_ready = 1'b0; instr_accept = 1'b1;
    tick();
    checkVal("neg_wrap_addr", imem_addr, 32'hFFFF_FFF8);
    checkVal("neg_wrap_cnt", fetch_count, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
